binary_digit_scanner: RTL and testbench
=======================================

# binary_digit_scanner

Upstream driver for the per-digit binary display decoders. It latches an ALU result word, time-multiplexes it across a bank of seven-segment digits one bit per digit, and presents the current digit's bit on `bitToDisplay` together with an active-low digit enable. Each digit shows one result bit as 0 or 1. Results wider than the digit bank are viewed in pages, and a page-step input walks through them.

## Interface
Parameters:
- `WIDTH`, default 8: ALU result width. Must be a multiple of `DIGITS`.
- `DIGITS`, default 4: number of physical digits.
- `REFRESH_DIV`, default 50000: clocks per digit slot. Must be ≥ 2.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `loadResult` in 1: one-cycle strobe that captures `aluResult`.
- `aluResult` in `WIDTH`: ALU output word.
- `nextPage` in 1: page-step level, already synchronised. Its rising edge advances the page.
- `bitToDisplay` out 1: bit for the currently enabled digit. Registered.
- `digitEnable` out `DIGITS`: one-hot-low digit select. All ones means all digits off. Registered.
- `pageIndex` out clog2(`WIDTH/DIGITS`), minimum 1 bit: current page. Registered.
- `resultValid` out 1: high once any result has been loaded.

## Operation
- State:
  - `held[WIDTH-1:0]`
  - `page` in 0..`PAGES`-1, where `PAGES` = `WIDTH/DIGITS`
  - `digit` in 0..`DIGITS`-1
  - prescaler `pre` in 0..`REFRESH_DIV`-1
  - `valid`
- Prescaler: increments every clock. At `REFRESH_DIV`-1 it wraps to 0 and `digit` advances, wrapping `DIGITS`-1 → 0. It is free-running and is not reset by a load.
- Load: when `loadResult`=1, `held`←`aluResult`, `valid`←1, `page`←0.
- Page step: a rising edge of `nextPage` (0 in the previous cycle, 1 now) sets `page`←`page`+1, wrapping `PAGES`-1 → 0. The step is ignored while `valid`=0.
- Simultaneous load and page edge: the load wins and `page`=0.
- Bit select: displayed bit index = `page`·`DIGITS` + `digit`. Digit 0 is the rightmost digit and shows the page LSB.
- Digit enable:
  - `digitEnable[digit]`=0 and all other bits 1.
  - Exception: all ones while `valid`=0.
  - Exception: all ones while `pre`=0. This is a one-clock anti-ghost blank at the start of every slot.
- While blanked, `bitToDisplay` still carries the selected bit. Downstream ignores it.
- `PAGES`=1 is legal. Page edges then leave `page` at 0.

## Timing
- Reset values:
  - `held`=0, `valid`=0, `page`=0, `digit`=0, `pre`=0
  - `bitToDisplay`=0, `digitEnable`=all ones, `pageIndex`=0, `resultValid`=0
  - The previous-`nextPage` register is 0.
- Outputs are registered from the internal state as it stood before each edge. Output latency is one clock behind state.
- Load sampled at edge k → `held`, `valid` and `page` update at edge k. `resultValid`, `pageIndex` and `bitToDisplay` reflect the new value at edge k+1.
- Page edge sampled at edge k → `pageIndex` and `bitToDisplay` update at edge k+1.
- Slot length: exactly `REFRESH_DIV` clocks per digit. Of these, `REFRESH_DIV`-1 clocks are enabled and 1 clock is blanked.
- Full scan period = `DIGITS`·`REFRESH_DIV` clocks.
- Reset asserted mid-scan: all state and outputs return to their reset values immediately (asynchronous). The first slot after release starts at `digit`=0, `pre`=0.

## Structure
- Shared package/header `scanner_pkg`:
  - `DIGIT_OFF` constant (all-ones enable pattern)
  - default `REFRESH_DIV`
  - a clog2 function for deriving `pageIndex` width
- One sub-module: `edge_detect`, a rising-edge detector on `nextPage` with an asynchronous active-low reset.
- Prescaler, digit counter, page counter and the output register stay in the top module.

## Test plan
Conditions: `WIDTH`=8, `DIGITS`=4, `REFRESH_DIV`=4.
1. Reset → `digitEnable`=4'b1111, `bitToDisplay`=0, `resultValid`=0, `pageIndex`=0. This holds for 50 clocks with no load.
2. Load 8'hA5, observe page 0 → over one scan, the enabled digit pattern is 1110, 1101, 1011, 0111, each held 3 clocks with 1 blank clock between. The bits shown are 1, 0, 1, 0.
3. Pulse `nextPage` → `pageIndex`=1 one clock after the edge, and the scan shows 0, 1, 0, 1. A second edge wraps `pageIndex` to 0.
4. Assert `loadResult` (8'h3C) in the same cycle as a `nextPage` rising edge while on page 1 → `pageIndex`=0 and digits show 0, 0, 1, 1.
5. Hold `nextPage` high for 20 clocks → exactly one page step occurs.
6. Assert `rst_n` low mid-slot with `digit`=2 → outputs go to reset values without waiting for a clock edge. After release, the first enabled pattern is 1110, reached after 1 blank clock.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared constants and helpers for the binary digit scanner and its sub-blocks.
package scanner_pkg;

  // Wide all-ones pattern; users truncate it to their digit count.
  localparam logic [31:0] DIGIT_OFF = '1;

  localparam int DEFAULT_REFRESH_DIV = 50000;

  // Ceiling log2, never less than 1 so that single-value counters still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on an already-synchronised level input.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b0;
    else        prev_reg <= level;
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/binary_digit_scanner.sv
// Latches an ALU result and multiplexes it one bit per seven-segment digit,
// paging through results wider than the digit bank.
module binary_digit_scanner
  import scanner_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int DIGITS      = 4,
  parameter  int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  localparam int PAGES       = WIDTH / DIGITS,
  localparam int PAGE_W      = clog2_min1(PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loadResult,
  input  logic [WIDTH-1:0]  aluResult,
  input  logic              nextPage,
  output logic              bitToDisplay,
  output logic [DIGITS-1:0] digitEnable,
  output logic [PAGE_W-1:0] pageIndex,
  output logic              resultValid
);

  localparam int DIGIT_W = clog2_min1(DIGITS);
  localparam int PRE_W   = clog2_min1(REFRESH_DIV);
  localparam int IDX_W   = clog2_min1(WIDTH);

  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);
  localparam logic [PAGE_W-1:0]  PAGE_LAST  = PAGE_W'(PAGES - 1);
  localparam logic [DIGITS-1:0]  ALL_OFF    = DIGITS'(DIGIT_OFF);

  logic [WIDTH-1:0]   held_reg;
  logic               valid_reg;
  logic [PAGE_W-1:0]  page_reg;
  logic [DIGIT_W-1:0] digit_reg;
  logic [PRE_W-1:0]   pre_reg;

  logic               page_step;
  logic [IDX_W-1:0]   bit_idx;
  logic [DIGITS-1:0]  enable_next;

  edge_detect u_page_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (nextPage),
    .rise  (page_step)
  );

  // The first clock of each slot is blanked so the previous digit's
  // segments never bleed into the next one while the select switches.
  always_comb begin
    bit_idx     = IDX_W'(page_reg) * IDX_W'(DIGITS) + IDX_W'(digit_reg);
    enable_next = ~(DIGITS'(1) << digit_reg);
    if (!valid_reg || pre_reg == '0) enable_next = ALL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg     <= '0;
      valid_reg    <= 1'b0;
      page_reg     <= '0;
      digit_reg    <= '0;
      pre_reg      <= '0;
      bitToDisplay <= 1'b0;
      digitEnable  <= ALL_OFF;
      pageIndex    <= '0;
      resultValid  <= 1'b0;
    end else begin
      if (pre_reg == PRE_LAST) begin
        pre_reg   <= '0;
        digit_reg <= (digit_reg == DIGIT_LAST) ? '0 : digit_reg + DIGIT_W'(1);
      end else begin
        pre_reg   <= pre_reg + PRE_W'(1);
      end

      // A load takes priority over a page step arriving in the same cycle.
      if (loadResult) begin
        held_reg  <= aluResult;
        valid_reg <= 1'b1;
        page_reg  <= '0;
      end else if (page_step && valid_reg) begin
        page_reg  <= (page_reg == PAGE_LAST) ? '0 : page_reg + PAGE_W'(1);
      end

      bitToDisplay <= held_reg[bit_idx];
      digitEnable  <= enable_next;
      pageIndex    <= page_reg;
      resultValid  <= valid_reg;
    end
  end

endmodule

// File: tb/tb_binary_digit_scanner.sv
// Self-checking bench: per-cycle scoreboard against a behavioural model,
// table-driven scan vectors and hand-written paging/reset sequences.
module tb_binary_digit_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       loadResult = 1'b0;
  logic [7:0] aluResult = 8'h00;
  logic       nextPage = 1'b0;
  logic       bitToDisplay;
  logic [3:0] digitEnable;
  logic [0:0] pageIndex;
  logic       resultValid;

  binary_digit_scanner #(
    .WIDTH       (8),
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .loadResult   (loadResult),
    .aluResult    (aluResult),
    .nextPage     (nextPage),
    .bitToDisplay (bitToDisplay),
    .digitEnable  (digitEnable),
    .pageIndex    (pageIndex),
    .resultValid  (resultValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       b;
    logic [3:0] en;
    logic       pidx;
    logic       v;
  } obs_t;

  obs_t sb_q[$];

  logic [7:0] m_held;
  logic       m_valid;
  logic       m_prev;
  int         m_page, m_digit, m_pre;

  logic [3:0] shown;
  int         en_cnt[4];
  int         blank_cnt;

  typedef struct {
    logic       do_load;
    logic [7:0] data;
    int         steps;
    logic       exp_pidx;
    logic [3:0] exp_bits;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 8'h00; m_valid = 1'b0; m_prev = 1'b0;
    m_page = 0; m_digit = 0; m_pre = 0;
    sb_q.delete();
  endtask

  // Push the expected outputs for the coming edge, advance the model, then compare.
  task automatic cycle();
    obs_t e, got;
    e.b    = m_held[m_page * 4 + m_digit];
    e.en   = (!m_valid || m_pre == 0) ? 4'hF : ~(4'b0001 << m_digit);
    e.pidx = m_page[0];
    e.v    = m_valid;
    sb_q.push_back(e);
    if (loadResult) begin
      m_held = aluResult; m_valid = 1'b1; m_page = 0;
    end else if (nextPage && !m_prev && m_valid) begin
      m_page = (m_page + 1) % 2;
    end
    m_prev = nextPage;
    if (m_pre == 3) begin
      m_pre = 0; m_digit = (m_digit + 1) % 4;
    end else begin
      m_pre = m_pre + 1;
    end
    @(posedge clk); #1;
    got = {bitToDisplay, digitEnable, pageIndex, resultValid};
    if (sb_q.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sb_q.pop_front();
      chk("scoreboard", got, e);
    end
  endtask

  task automatic load(input logic [7:0] d);
    loadResult = 1'b1; aluResult = d;
    cycle();
    loadResult = 1'b0;
  endtask

  task automatic step();
    nextPage = 1'b1; cycle();
    nextPage = 1'b0; cycle();
  endtask

  // One full scan period: record the bit each enabled digit shows.
  task automatic scan();
    shown = 4'b0000; blank_cnt = 0;
    for (int i = 0; i < 4; i++) en_cnt[i] = 0;
    repeat (16) begin
      cycle();
      case (digitEnable)
        4'b1110: begin shown[0] = bitToDisplay; en_cnt[0]++; end
        4'b1101: begin shown[1] = bitToDisplay; en_cnt[1]++; end
        4'b1011: begin shown[2] = bitToDisplay; en_cnt[2]++; end
        4'b0111: begin shown[3] = bitToDisplay; en_cnt[3]++; end
        4'b1111: blank_cnt++;
        default: chk("enable_onehot", digitEnable, 4'hF);
      endcase
    end
  endtask

  initial begin
    int n, changes;
    logic prev_p;

    vecs[0] = '{do_load: 1'b1, data: 8'hA5, steps: 0, exp_pidx: 1'b0, exp_bits: 4'b0101};
    vecs[1] = '{do_load: 1'b0, data: 8'h00, steps: 1, exp_pidx: 1'b1, exp_bits: 4'b1010};
    vecs[2] = '{do_load: 1'b0, data: 8'h00, steps: 1, exp_pidx: 1'b0, exp_bits: 4'b0101};

    // Reset state
    @(posedge clk); #1;
    chk("rst_en", digitEnable, 4'hF);
    chk("rst_bit", bitToDisplay, 0);
    chk("rst_valid", resultValid, 0);
    chk("rst_pidx", pageIndex, 0);
    model_reset();
    rst_n = 1'b1;
    repeat (50) cycle();
    chk("idle_en", digitEnable, 4'hF);
    chk("idle_valid", resultValid, 0);
    $display("idle 50 clocks: en=%b valid=%0d", digitEnable, resultValid);

    // Table-driven scans
    for (int v = 0; v < 3; v++) begin
      if (vecs[v].do_load) load(vecs[v].data);
      for (int s = 0; s < vecs[v].steps; s++) step();
      scan();
      chk("vec_bits", shown, vecs[v].exp_bits);
      chk("vec_pidx", pageIndex, vecs[v].exp_pidx);
      chk("vec_blank", blank_cnt, 4);
      for (int d = 0; d < 4; d++) chk("vec_slot_len", en_cnt[d], 3);
      $display("vec %0d: page=%0d shown=%b blanks=%0d", v, pageIndex, shown, blank_cnt);
    end

    // Page index lags the step edge by one clock
    nextPage = 1'b1; cycle();
    chk("step_lag0", pageIndex, 0);
    nextPage = 1'b0; cycle();
    chk("step_lag1", pageIndex, 1);
    $display("page step: pageIndex=%0d", pageIndex);

    // Load and page edge together: load wins
    loadResult = 1'b1; aluResult = 8'h3C; nextPage = 1'b1;
    cycle();
    loadResult = 1'b0; nextPage = 1'b0;
    cycle();
    chk("collide_pidx", pageIndex, 0);
    scan();
    chk("collide_bits", shown, 4'b1100);
    chk("collide_pidx2", pageIndex, 0);
    $display("load+step collision: page=%0d shown=%b", pageIndex, shown);

    // Held level gives exactly one step
    nextPage = 1'b1;
    prev_p = pageIndex[0];
    changes = 0;
    repeat (20) begin
      cycle();
      if (pageIndex[0] !== prev_p) changes++;
      prev_p = pageIndex[0];
    end
    nextPage = 1'b0;
    cycle();
    chk("held_steps", changes, 1);
    chk("held_pidx", pageIndex, 1);
    $display("nextPage held 20 clocks: steps=%0d page=%0d", changes, pageIndex);

    // Asynchronous reset mid-slot on digit 2
    n = 0;
    while (!(m_digit == 2 && m_pre == 2) && n < 40) begin
      cycle();
      n++;
    end
    chk("wait_digit2", (n < 40), 1);
    chk("pre_rst_en", digitEnable, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", digitEnable, 4'hF);
    chk("async_bit", bitToDisplay, 0);
    chk("async_valid", resultValid, 0);
    chk("async_pidx", pageIndex, 0);
    model_reset();
    @(posedge clk); #1;
    loadResult = 1'b1; aluResult = 8'hA5;
    rst_n = 1'b1;
    cycle();
    loadResult = 1'b0;
    chk("post_rst_blank", digitEnable, 4'hF);
    cycle();
    chk("post_rst_first", digitEnable, 4'b1110);
    chk("post_rst_bit", bitToDisplay, 1);
    $display("reset mid-slot: first enable=%b bit=%0d", digitEnable, bitToDisplay);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
